// File: rtl/ethernet_frame_arbiter_8ch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ethernet_frame_arbiter_8ch                                 |
// | Description : 8:1 frame-granular strict-priority arbiter for 8-bit       |
// |               AXI4-Stream Ethernet frames. Input 7 has the highest       |
// |               priority. A granted input owns the output until its tlast  |
// |               beat. Frames flagged bad on tuser (first beat) may be      |
// |               consumed and discarded (DROP_ENABLE=1).                    |
// | Ports       : clk, rst (sync, active-high)                               |
// |               s_axis_N_{tdata,tvalid,tready,tlast,tuser}, N = 7..0       |
// |               m_axis_{tdata,tvalid,tready,tlast,tuser}                   |
// |               dropped_frames (32b, only with the macro below)            |
// | Options     : `define ETHERNET_FRAME_ARBITER_DROP_COUNTER_EN adds a      |
// |               saturating counter of discarded frames.                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ethernet_frame_arbiter_8ch #(
   parameter int unsigned DROP_ENABLE = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  s_axis_7_tdata,
   input  logic        s_axis_7_tvalid,
   output logic        s_axis_7_tready,
   input  logic        s_axis_7_tlast,
   input  logic        s_axis_7_tuser,
   input  logic [7:0]  s_axis_6_tdata,
   input  logic        s_axis_6_tvalid,
   output logic        s_axis_6_tready,
   input  logic        s_axis_6_tlast,
   input  logic        s_axis_6_tuser,
   input  logic [7:0]  s_axis_5_tdata,
   input  logic        s_axis_5_tvalid,
   output logic        s_axis_5_tready,
   input  logic        s_axis_5_tlast,
   input  logic        s_axis_5_tuser,
   input  logic [7:0]  s_axis_4_tdata,
   input  logic        s_axis_4_tvalid,
   output logic        s_axis_4_tready,
   input  logic        s_axis_4_tlast,
   input  logic        s_axis_4_tuser,
   input  logic [7:0]  s_axis_3_tdata,
   input  logic        s_axis_3_tvalid,
   output logic        s_axis_3_tready,
   input  logic        s_axis_3_tlast,
   input  logic        s_axis_3_tuser,
   input  logic [7:0]  s_axis_2_tdata,
   input  logic        s_axis_2_tvalid,
   output logic        s_axis_2_tready,
   input  logic        s_axis_2_tlast,
   input  logic        s_axis_2_tuser,
   input  logic [7:0]  s_axis_1_tdata,
   input  logic        s_axis_1_tvalid,
   output logic        s_axis_1_tready,
   input  logic        s_axis_1_tlast,
   input  logic        s_axis_1_tuser,
   input  logic [7:0]  s_axis_0_tdata,
   input  logic        s_axis_0_tvalid,
   output logic        s_axis_0_tready,
   input  logic        s_axis_0_tlast,
   input  logic        s_axis_0_tuser,
   output logic [7:0]  m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        m_axis_tlast,
   output logic        m_axis_tuser
`ifdef ETHERNET_FRAME_ARBITER_DROP_COUNTER_EN
   ,
   output logic [31:0] dropped_frames
`endif
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] FORWARD = 2'd1;
   localparam logic [1:0] DROP    = 2'd2;

   // Inputs gathered into vectors indexed by channel number.
   logic [7:0][7:0] tdata;
   logic [7:0]      tvalid;
   logic [7:0]      tlast;
   logic [7:0]      tuser;
   logic [7:0]      tready;

   assign tdata  = {s_axis_7_tdata,  s_axis_6_tdata,  s_axis_5_tdata,  s_axis_4_tdata,
                    s_axis_3_tdata,  s_axis_2_tdata,  s_axis_1_tdata,  s_axis_0_tdata};
   assign tvalid = {s_axis_7_tvalid, s_axis_6_tvalid, s_axis_5_tvalid, s_axis_4_tvalid,
                    s_axis_3_tvalid, s_axis_2_tvalid, s_axis_1_tvalid, s_axis_0_tvalid};
   assign tlast  = {s_axis_7_tlast,  s_axis_6_tlast,  s_axis_5_tlast,  s_axis_4_tlast,
                    s_axis_3_tlast,  s_axis_2_tlast,  s_axis_1_tlast,  s_axis_0_tlast};
   assign tuser  = {s_axis_7_tuser,  s_axis_6_tuser,  s_axis_5_tuser,  s_axis_4_tuser,
                    s_axis_3_tuser,  s_axis_2_tuser,  s_axis_1_tuser,  s_axis_0_tuser};
   assign {s_axis_7_tready, s_axis_6_tready, s_axis_5_tready, s_axis_4_tready,
           s_axis_3_tready, s_axis_2_tready, s_axis_1_tready, s_axis_0_tready} = tready;

   logic [1:0] state;
   logic [2:0] grant;
   logic [2:0] winner;
   logic       drop_mode;

   assign drop_mode = (DROP_ENABLE != 0);

   // Highest-numbered valid input wins; later iterations override earlier ones.
   always_comb begin
      winner = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (tvalid[i]) winner = 3'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         grant <= 3'd0;
      end else begin
         case (state)
            IDLE: begin
               if (|tvalid) begin
                  grant <= winner;
                  // Drop decision uses tuser of the first beat only.
                  state <= (drop_mode && tuser[winner]) ? DROP : FORWARD;
               end
            end
            FORWARD: begin
               if (tvalid[grant] && m_axis_tready && tlast[grant]) state <= IDLE;
            end
            DROP: begin
               if (tvalid[grant] && tlast[grant]) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Zero-latency data path from the granted input; everything idles at 0.
   always_comb begin
      tready        = 8'd0;
      m_axis_tdata  = 8'd0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      m_axis_tuser  = 1'b0;
      case (state)
         FORWARD: begin
            tready[grant] = m_axis_tready;
            m_axis_tdata  = tdata[grant];
            m_axis_tvalid = tvalid[grant];
            m_axis_tlast  = tlast[grant];
            m_axis_tuser  = drop_mode ? 1'b0 : tuser[grant];
         end
         DROP: begin
            tready[grant] = 1'b1;
         end
         default: ;
      endcase
   end

`ifdef ETHERNET_FRAME_ARBITER_DROP_COUNTER_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         dropped_frames <= 32'd0;
      end else if (state == DROP && tvalid[grant] && tlast[grant] &&
                   dropped_frames != 32'hFFFF_FFFF) begin
         dropped_frames <= dropped_frames + 32'd1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ethernet_frame_arbiter_8ch.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : tb_ethernet_frame_arbiter_8ch                              |
// | Description : Self-checking bench for ethernet_frame_arbiter_8ch. Sources|
// |               are per-channel beat queues; the reference keeps, per      |
// |               channel, the bytes that must appear on the output and the  |
// |               number of beats that must be swallowed.                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_ethernet_frame_arbiter_8ch;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [7:0] s_tdata [8];
   logic [7:0] s_tvalid, s_tready, s_tlast, s_tuser;
   logic [7:0] m_tdata;
   logic       m_tvalid, m_tready, m_tlast, m_tuser;
`ifdef ETHERNET_FRAME_ARBITER_DROP_COUNTER_EN
   logic [31:0] dropped_frames;
`endif

   ethernet_frame_arbiter_8ch #(.DROP_ENABLE(1)) dut (
      .clk(clk), .rst(rst),
      .s_axis_7_tdata(s_tdata[7]), .s_axis_7_tvalid(s_tvalid[7]), .s_axis_7_tready(s_tready[7]),
      .s_axis_7_tlast(s_tlast[7]), .s_axis_7_tuser(s_tuser[7]),
      .s_axis_6_tdata(s_tdata[6]), .s_axis_6_tvalid(s_tvalid[6]), .s_axis_6_tready(s_tready[6]),
      .s_axis_6_tlast(s_tlast[6]), .s_axis_6_tuser(s_tuser[6]),
      .s_axis_5_tdata(s_tdata[5]), .s_axis_5_tvalid(s_tvalid[5]), .s_axis_5_tready(s_tready[5]),
      .s_axis_5_tlast(s_tlast[5]), .s_axis_5_tuser(s_tuser[5]),
      .s_axis_4_tdata(s_tdata[4]), .s_axis_4_tvalid(s_tvalid[4]), .s_axis_4_tready(s_tready[4]),
      .s_axis_4_tlast(s_tlast[4]), .s_axis_4_tuser(s_tuser[4]),
      .s_axis_3_tdata(s_tdata[3]), .s_axis_3_tvalid(s_tvalid[3]), .s_axis_3_tready(s_tready[3]),
      .s_axis_3_tlast(s_tlast[3]), .s_axis_3_tuser(s_tuser[3]),
      .s_axis_2_tdata(s_tdata[2]), .s_axis_2_tvalid(s_tvalid[2]), .s_axis_2_tready(s_tready[2]),
      .s_axis_2_tlast(s_tlast[2]), .s_axis_2_tuser(s_tuser[2]),
      .s_axis_1_tdata(s_tdata[1]), .s_axis_1_tvalid(s_tvalid[1]), .s_axis_1_tready(s_tready[1]),
      .s_axis_1_tlast(s_tlast[1]), .s_axis_1_tuser(s_tuser[1]),
      .s_axis_0_tdata(s_tdata[0]), .s_axis_0_tvalid(s_tvalid[0]), .s_axis_0_tready(s_tready[0]),
      .s_axis_0_tlast(s_tlast[0]), .s_axis_0_tuser(s_tuser[0]),
      .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
      .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser)
`ifdef ETHERNET_FRAME_ARBITER_DROP_COUNTER_EN
      , .dropped_frames(dropped_frames)
`endif
   );

   typedef struct packed {logic [7:0] d; logic l; logic u;} beat_t;
   typedef struct {int src; int first; int last; int beats;} rec_t;

   beat_t src_q [8][$];   // beats still to be presented by each source
   beat_t exp_q [8][$];   // bytes each source must still deliver on the output
   rec_t  recs [$];       // completed output frames
   int    drop_exp  [8];
   int    drop_seen [8];
   int    exp_df;

   int   n_tests = 0, n_fail = 0;
   int   cycle = 0;
   bit   in_frame = 0;
   int   cur_src = 0, cur_first = 0, cur_beats = 0;
   logic [7:0] acc = 8'd0;
   bit   flush = 0;
   int   ready_mode = 0;
   logic ready_man = 1'b0;
   int   set_len [10];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cycle);
      end
   endtask

   // Queue one frame on source s. Later-beat tuser is random: it must not matter.
   task automatic push_frame(input int s, input int len, input bit bad, input int seed);
      beat_t b;
      for (int k = 0; k < len; k++) begin
         b.d = 8'((seed * 97) ^ (k * 29) ^ (k >> 2) ^ (seed >> 3));
         b.l = (k == len - 1);
         b.u = (k == 0) ? bad : 1'($urandom_range(0, 1));
         src_q[s].push_back(b);
         if (!bad) exp_q[s].push_back(b);
      end
      if (bad) begin
         drop_exp[s] += len;
         exp_df++;
      end
   endtask

   task automatic drain(input int budget, input string tag);
      int n = 0;
      bit busy = 1;
      while (busy && n < budget) begin
         @(negedge clk); #1;
         n++;
         busy = in_frame;
         for (int i = 0; i < 8; i++)
            if (src_q[i].size() != 0 || exp_q[i].size() != 0) busy = 1;
      end
      check({tag, "_drain_timeout"}, 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_beats(input int s, input int nb, input string tag);
      int n = 0;
      bit ok = 0;
      while (!ok && n < 3000) begin
         @(negedge clk); #1;
         n++;
         ok = in_frame && cur_src == s && cur_beats >= nb;
      end
      check({tag, "_wait_timeout"}, 32'(ok), 32'd1);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_tvalid"}, 32'(m_tvalid), 32'd0);
      check({tag, "_tdata"},  32'(m_tdata),  32'd0);
      check({tag, "_tlast"},  32'(m_tlast),  32'd0);
      check({tag, "_tuser"},  32'(m_tuser),  32'd0);
      check({tag, "_treadys"}, 32'(s_tready), 32'd0);
`ifdef ETHERNET_FRAME_ARBITER_DROP_COUNTER_EN
      check({tag, "_dropped"}, dropped_frames, 32'd0);
`endif
   endtask

   // Source driver and downstream ready generator: update just after each rising edge.
   initial begin
      s_tvalid = '0; s_tlast = '0; s_tuser = '0; m_tready = 1'b0;
      for (int i = 0; i < 8; i++) s_tdata[i] = 8'd0;
      forever begin
         @(posedge clk); #1;
         for (int i = 0; i < 8; i++) begin
            if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (flush) src_q[i].delete();
            if (src_q[i].size() > 0) begin
               s_tvalid[i] = 1'b1;
               s_tdata[i]  = src_q[i][0].d;
               s_tlast[i]  = src_q[i][0].l;
               s_tuser[i]  = src_q[i][0].u;
            end else begin
               s_tvalid[i] = 1'b0;
               s_tdata[i]  = 8'd0;
               s_tlast[i]  = 1'b0;
               s_tuser[i]  = 1'b0;
            end
         end
         case (ready_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = 1'($urandom_range(0, 1));
            default: m_tready = ready_man;
         endcase
      end
   end

   // Output monitor / scoreboard, sampled mid-cycle.
   initial begin
      forever begin
         int    nrdy;
         int    s;
         logic  outb;
         beat_t e;
         rec_t  r;
         @(negedge clk);
         cycle++;
         nrdy = 0;
         s = -1;
         for (int i = 0; i < 8; i++) begin
            acc[i] = s_tvalid[i] & s_tready[i];
            if (s_tready[i]) nrdy++;
         end
         check("ready_onehot", 32'(nrdy <= 1), 32'd1);
         outb = m_tvalid & m_tready;
         if (outb) begin
            for (int i = 0; i < 8; i++) if (acc[i]) s = i;
            check("beat_source_found", 32'(s >= 0), 32'd1);
            if (s >= 0) begin
               if (!in_frame) begin
                  in_frame = 1; cur_src = s; cur_first = cycle; cur_beats = 0;
               end
               check("no_interleave", 32'(s), 32'(cur_src));
               cur_beats++;
               check("beat_expected", 32'(exp_q[s].size() > 0), 32'd1);
               if (exp_q[s].size() > 0) begin
                  e = exp_q[s].pop_front();
                  check("tdata", 32'(m_tdata), 32'(e.d));
                  check("tlast", 32'(m_tlast), 32'(e.l));
               end
               check("tuser_zero", 32'(m_tuser), 32'd0);
               if (m_tlast) begin
                  r.src = cur_src; r.first = cur_first; r.last = cycle; r.beats = cur_beats;
                  recs.push_back(r);
                  in_frame = 0;
               end
            end
         end
         for (int i = 0; i < 8; i++)
            if (acc[i] && !(outb && s == i)) drop_seen[i]++;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cycle);
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      int tgt;
      for (int i = 0; i < 8; i++) begin drop_exp[i] = 0; drop_seen[i] = 0; end
      exp_df = 0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check_idle_outputs("reset");
      rst = 1'b0;

      // All eight inputs valid in the same cycle.
      ready_mode = 0;
      recs.delete();
      for (int i = 0; i < 8; i++) push_frame(i, 64, 0, int'($urandom));
      drain(3000, "all8");
      check("all8_frames", 32'(recs.size()), 32'd8);
      if (recs.size() == 8) begin
         for (int k = 0; k < 8; k++) begin
            check("all8_order", 32'(recs[k].src), 32'(7 - k));
            check("all8_len", 32'(recs[k].beats), 32'd64);
         end
         for (int k = 1; k < 8; k++)
            check("all8_gap", 32'(recs[k].first - recs[k-1].last), 32'd2);
      end

      // No pre-emption: input 7 arrives while input 2 is mid-frame.
      recs.delete();
      push_frame(2, 30, 0, int'($urandom));
      wait_beats(2, 5, "preempt");
      push_frame(7, 20, 0, int'($urandom));
      drain(2000, "preempt");
      check("preempt_frames", 32'(recs.size()), 32'd2);
      if (recs.size() == 2) begin
         check("preempt_first", 32'(recs[0].src), 32'd2);
         check("preempt_second", 32'(recs[1].src), 32'd7);
      end

      // 100-byte frame under random backpressure.
      ready_mode = 1;
      recs.delete();
      tgt = int'($urandom_range(0, 7));
      push_frame(tgt, 100, 0, int'($urandom));
      drain(3000, "bp");
      check("bp_frames", 32'(recs.size()), 32'd1);
      if (recs.size() == 1) begin
         check("bp_beats", 32'(recs[0].beats), 32'd100);
         check("bp_src", 32'(recs[0].src), 32'(tgt));
      end

      // Bad frame then clean frame on input 3.
      recs.delete();
      push_frame(3, 25, 1, int'($urandom));
      push_frame(3, 40, 0, int'($urandom));
      drain(2000, "drop");
      check("drop_frames_out", 32'(recs.size()), 32'd1);
      if (recs.size() == 1) check("drop_clean_len", 32'(recs[0].beats), 32'd40);
      check("drop_beats_3", 32'(drop_seen[3]), 32'(drop_exp[3]));
`ifdef ETHERNET_FRAME_ARBITER_DROP_COUNTER_EN
      check("drop_counter", dropped_frames, 32'd1);
`endif

      // Reset after byte 10 of a 60-byte frame.
      ready_mode = 0;
      recs.delete();
      push_frame(6, 60, 0, int'($urandom));
      wait_beats(6, 10, "rst");
      rst = 1'b1;
      flush = 1;
      exp_q[6].delete();
      in_frame = 0;
      exp_df = 0;
      @(negedge clk); #1;
      check_idle_outputs("midrst");
      rst = 1'b0;
      flush = 0;
      push_frame(5, 12, 0, int'($urandom));
      push_frame(1, 8, 0, int'($urandom));
      drain(1000, "postrst");
      check("postrst_frames", 32'(recs.size()), 32'd2);
      if (recs.size() == 2) begin
         check("postrst_first", 32'(recs[0].src), 32'd5);
         check("postrst_second", 32'(recs[1].src), 32'd1);
      end

      // Staggered sources sharing one frame set.
      for (int f = 0; f < 10; f++) set_len[f] = int'($urandom_range(1, 150));
      recs.delete();
      ready_mode = 2;
      ready_man  = 1'b0;
      for (int rel = 0; rel <= 20 + 1600 * 7; rel++) begin
         @(negedge clk); #1;
         if (rel == 50) ready_man = 1'b1;
         if (rel == 51) ready_man = 1'b0;
         if (rel == 52) ready_man = 1'b1;
         for (int i = 0; i < 8; i++)
            if (rel == 20 + 1600 * i)
               for (int f = 0; f < 10; f++) push_frame(i, set_len[f], 0, f + 100);
      end
      drain(5000, "stagger");
      check("stagger_frames", 32'(recs.size()), 32'd80);
      for (int i = 0; i < 8; i++) begin
         cnt = 0;
         foreach (recs[k]) if (recs[k].src == i) cnt++;
         check("stagger_per_src", 32'(cnt), 32'd10);
      end

      // Random traffic with random bad frames and backpressure.
      ready_mode = 1;
      repeat (2500) begin
         @(negedge clk); #1;
         if ($urandom_range(0, 47) == 0)
            push_frame(int'($urandom_range(0, 7)), int'($urandom_range(1, 40)),
                       $urandom_range(0, 4) == 0, int'($urandom));
      end
      drain(20000, "random");
      for (int i = 0; i < 8; i++) begin
         check("final_exp_empty", 32'(exp_q[i].size()), 32'd0);
         check("final_drop_beats", 32'(drop_seen[i]), 32'(drop_exp[i]));
      end
`ifdef ETHERNET_FRAME_ARBITER_DROP_COUNTER_EN
      check("final_drop_counter", dropped_frames, 32'(exp_df));
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ethernet_frame_arbiter_8ch.md
Name: ethernet_frame_arbiter_8ch

Overview:
- 8-input to 1-output, frame-granular, strict-priority arbiter for 8-bit AXI4-Stream Ethernet frames.
- Sits in front of an egress FIFO and merges per-traffic-class queues (input 7 = highest class) into one egress stream.
- Once granted, an input keeps the output until its tlast beat; frames are never interleaved.
- Optionally discards frames that are flagged bad on tuser.

Parameters:
- DROP_ENABLE, 1, 1: input frames flagged by tuser are consumed and discarded; 0: tuser is passed through to m_axis_tuser.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- s_axis_N_tdata  in  8  frame byte, input N (N = 7..0).
- s_axis_N_tvalid  in  1  beat valid, input N.
- s_axis_N_tready  out  1  beat accepted, input N.
- s_axis_N_tlast  in  1  last byte of frame, input N.
- s_axis_N_tuser  in  1  bad-frame flag, input N.
- m_axis_tdata  out  8  merged frame byte.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last byte of output frame.
- m_axis_tuser  out  1  pass-through flag; 0 when DROP_ENABLE=1.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, grant cleared, all s_axis_N_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0.
  - Reset mid-frame abandons the frame: the remainder is not forwarded; the next grant starts fresh.
- State machine: IDLE, FORWARD, DROP. The grant index (3 bits) is a register.
- IDLE:
  - All treadys are 0 and m_axis_tvalid is 0.
  - If any tvalid is high, latch the highest-numbered valid input as grant (7 beats 6 ... beats 0).
  - Next state is DROP if DROP_ENABLE=1 and that input's tuser=1 on its current (first) beat; otherwise FORWARD.
  - Decision latency is one cycle, so there is exactly one idle cycle between consecutive frames.
- FORWARD (combinational data path, zero added latency):
  - m_axis_tdata/tvalid/tlast come from the granted input.
  - m_axis_tuser = granted tuser if DROP_ENABLE=0, else 0.
  - s_axis_grant_tready = m_axis_tready; all other treadys are 0.
  - When tvalid&&tready&&tlast on the granted input: go to IDLE.
  - Backpressure: while m_axis_tready=0, hold; no beat is lost or duplicated.
- DROP:
  - s_axis_grant_tready=1 unconditionally; m_axis_tvalid=0.
  - Each accepted beat is discarded; on the accepted tlast beat, go to IDLE.
- tuser is sampled only on the first beat of a frame; tuser on later beats is ignored for the drop decision.
- Non-granted inputs are never accepted; they wait with their data stable, per AXI-Stream rules.
- Simultaneous requests: the highest index wins. Lower inputs can starve under continuous high-priority load; this is by design.
- Arbitration is never pre-empted mid-frame, even if a higher-priority input becomes valid.
- Zero-length frames do not exist: a single-beat frame has tlast on its first beat and is handled normally.

Optional Feature:
- Macro ETHERNET_FRAME_ARBITER_DROP_COUNTER_EN.
- When defined:
  - Adds output port dropped_frames (32 bits).
  - Increments by 1 on each accepted tlast beat in DROP state; saturates at 0xFFFFFFFF.
  - Cleared to 0 by rst.
- When undefined: the port and the counter do not exist; all other behaviour is identical.

Test Plan:
- Staggered sources: input 0 starts sending at cycle 20, input 1 at 1620, ..., input 7 at 11220, all with the same frame set; downstream ready from cycle 50 with a 1-cycle ready drop at 51 -> output carries all 8 frame sets byte-exact, tlast aligned, no interleaving.
- All 8 inputs valid in the same cycle with 64-byte frames -> output order is 7,6,5,4,3,2,1,0; one idle cycle between frames.
- Input 2 mid-frame when input 7 becomes valid -> input 2 frame completes first, then input 7.
- m_axis_tready toggled randomly 50% during a 100-byte frame -> exactly 100 output beats, data identical, tlast only on beat 100.
- DROP_ENABLE=1, input 3 frame with tuser=1 on its first beat, followed by a clean frame on input 3 -> first frame fully consumed with no output beats; second frame forwarded intact; dropped_frames=1 when the macro is defined.
- rst asserted for 1 cycle after byte 10 of a 60-byte frame -> all outputs 0 the next cycle; state IDLE; subsequent frames arbitrate normally.
